// File: rtl/ethernet_tx.sv
// RMII Ethernet transmitter: turns one 16-bit read response into a fixed 72-byte
// frame (preamble, MAC header, 46-byte payload, CRC-32 FCS) sent 2 bits per clock.
module ethernet_tx #(
   parameter logic [47:0] FPGA_MAC  = 48'h0,
   parameter logic [47:0] HOST_MAC  = 48'h0,
   parameter logic [15:0] ETHERTYPE = 16'h0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] data_i,
   input  logic        rw_i,
   input  logic        valid_i,
   output logic        txen,
   output logic [1:0]  txd,
   output logic        busy_o
);

   localparam int unsigned CNT_W    = 8;
   localparam int unsigned PRE_LEN  = 32;
   localparam int unsigned DATA_LEN = 240;
   localparam int unsigned FCS_LEN  = 16;
   localparam int unsigned IFG_LEN  = 48;
   localparam int unsigned HDR_W    = 128;
   localparam logic [31:0] CRC_POLY = 32'hEDB8_8320;
   localparam logic [31:0] CRC_INIT = 32'hFFFF_FFFF;

   typedef enum logic [2:0] {S_IDLE, S_PRE, S_DATA, S_FCS, S_IFG} state_t;

   state_t             r_state, w_state_nxt;
   logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
   logic [15:0]        r_data;
   logic [31:0]        r_crc;
   logic               r_txen, r_busy;
   logic [1:0]         r_txd;
   logic               w_accept, w_txen;
   logic [1:0]         w_dibit;
   logic [HDR_W-1:0]   w_hdr, w_hdr_sh;
   logic [7:0]         w_byte;

   // Reflected CRC-32 advanced by one dibit, bit 0 first.
   function automatic logic [31:0] crc_dibit(input logic [31:0] c, input logic [1:0] d);
      logic [31:0] x;
      x = c;
      for (int i = 0; i < 2; i++) begin
         x = (x[0] ^ d[i]) ? ((x >> 1) ^ CRC_POLY) : (x >> 1);
      end
      return x;
   endfunction

   // Non-zero part of the DATA phase; bytes 16..59 shift out as zero.
   assign w_hdr    = {HOST_MAC, FPGA_MAC, ETHERTYPE, r_data};
   assign w_hdr_sh = w_hdr << {r_cnt[7:2], 3'b000};
   assign w_byte   = w_hdr_sh[HDR_W-1 -: 8];

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt + CNT_W'(1);
      w_accept    = 1'b0;
      w_txen      = 1'b0;
      w_dibit     = 2'b00;
      unique case (r_state)
         S_IDLE: begin
            w_cnt_nxt = '0;
            if (valid_i && !rw_i) begin
               w_accept    = 1'b1;
               w_state_nxt = S_PRE;
            end
         end
         S_PRE: begin
            w_txen  = 1'b1;
            w_dibit = (r_cnt == CNT_W'(PRE_LEN - 1)) ? 2'b11 : 2'b01;
            if (r_cnt == CNT_W'(PRE_LEN - 1)) begin
               w_state_nxt = S_DATA;
               w_cnt_nxt   = '0;
            end
         end
         S_DATA: begin
            w_txen = 1'b1;
            unique case (r_cnt[1:0])
               2'd0:    w_dibit = w_byte[1:0];
               2'd1:    w_dibit = w_byte[3:2];
               2'd2:    w_dibit = w_byte[5:4];
               default: w_dibit = w_byte[7:6];
            endcase
            if (r_cnt == CNT_W'(DATA_LEN - 1)) begin
               w_state_nxt = S_FCS;
               w_cnt_nxt   = '0;
            end
         end
         S_FCS: begin
            w_txen  = 1'b1;
            w_dibit = ~r_crc[1:0];
            if (r_cnt == CNT_W'(FCS_LEN - 1)) begin
               w_state_nxt = S_IFG;
               w_cnt_nxt   = '0;
            end
         end
         S_IFG: begin
            if (r_cnt == CNT_W'(IFG_LEN - 1)) begin
               w_state_nxt = S_IDLE;
               w_cnt_nxt   = '0;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_data  <= '0;
         r_crc   <= CRC_INIT;
         r_txen  <= 1'b0;
         r_txd   <= 2'b00;
         r_busy  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         if (w_accept) r_data <= data_i;
         r_txen  <= w_txen;
         r_txd   <= w_dibit;
         r_busy  <= (r_state != S_IDLE);
         // CRC accumulates over DATA, then is drained LSB first during FCS.
         unique case (r_state)
            S_DATA:  r_crc <= crc_dibit(r_crc, w_dibit);
            S_FCS:   r_crc <= {2'b11, r_crc[31:2]};
            default: r_crc <= CRC_INIT;
         endcase
      end
   end

   assign txen   = r_txen;
   assign txd    = r_txd;
   assign busy_o = r_busy;

endmodule

// File: tb/tb_ethernet_tx.sv
// Directed self-checking bench for ethernet_tx: frame content, FCS, timing,
// write filtering, back-to-back drop and mid-frame reset.
module tb_ethernet_tx;

   localparam logic [47:0] P_FPGA  = 48'h12_34_56_78_9A_BC;
   localparam logic [47:0] P_HOST  = 48'hFF_FF_FF_FF_FF_FF;
   localparam logic [15:0] P_ETYPE = 16'h88B5;

   logic        clk;
   logic        rst;
   logic [15:0] data_i;
   logic        rw_i;
   logic        valid_i;
   logic        txen;
   logic [1:0]  txd;
   logic        busy_o;

   int total = 0;
   int bad   = 0;

   logic [7:0] fr     [72];
   logic [7:0] exp_fr [72];

   ethernet_tx #(
      .FPGA_MAC (P_FPGA),
      .HOST_MAC (P_HOST),
      .ETHERTYPE(P_ETYPE)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .data_i (data_i),
      .rw_i   (rw_i),
      .valid_i(valid_i),
      .txen   (txen),
      .txd    (txd),
      .busy_o (busy_o)
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   // Bitwise reflected CRC register over captured bytes lo..hi (no final complement).
   function automatic logic [31:0] crc_over(input int lo, input int hi);
      logic [31:0] c;
      c = 32'hFFFF_FFFF;
      for (int i = lo; i <= hi; i++)
         for (int b = 0; b < 8; b++)
            c = (c[0] ^ fr[i][b]) ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
      return c;
   endfunction

   task automatic build_exp(input logic [15:0] d);
      logic [47:0] host, fpga;
      logic [31:0] c;
      host = P_HOST;
      fpga = P_FPGA;
      for (int i = 0; i < 7; i++) exp_fr[i] = 8'h55;
      exp_fr[7] = 8'hD5;
      for (int i = 0; i < 6; i++) begin
         exp_fr[8 + i]  = host[47 - 8*i -: 8];
         exp_fr[14 + i] = fpga[47 - 8*i -: 8];
      end
      exp_fr[20] = 8'h88;
      exp_fr[21] = 8'hB5;
      exp_fr[22] = d[15:8];
      exp_fr[23] = d[7:0];
      for (int i = 24; i < 68; i++) exp_fr[i] = 8'h00;
      c = 32'hFFFF_FFFF;
      for (int i = 8; i < 68; i++)
         for (int b = 0; b < 8; b++)
            c = (c[0] ^ exp_fr[i][b]) ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
      c = ~c;
      for (int i = 0; i < 4; i++) exp_fr[68 + i] = c[8*i +: 8];
   endtask

   task automatic send_req(input logic [15:0] d, input logic rw);
      @(posedge clk); #1;
      data_i  = d;
      rw_i    = rw;
      valid_i = 1'b1;
      @(posedge clk); #1;
      valid_i = 1'b0;
      rw_i    = 1'b0;
   endtask

   // Deserialize dibits while txen is high; returns number of txen-high cycles.
   task automatic capture(output int n);
      int w;
      int idx;
      n = 0;
      w = 0;
      for (int i = 0; i < 72; i++) fr[i] = 8'hXX;
      while (!txen && w < 5) begin
         @(posedge clk); #1;
         w++;
      end
      while (txen && n < 400) begin
         if (n < 288) begin
            idx = n / 4;
            fr[idx][2*(n % 4) +: 2] = txd;
         end
         n++;
         @(posedge clk); #1;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; valid_i = 1'b1; rw_i = 1'b0; data_i = 16'hDEAD;
      repeat (3) @(posedge clk);
      #1;
      total++; if (txen !== 1'b0)  begin bad++; $display("FAIL reset_txen got=%b want=0", txen); end
      total++; if (txd !== 2'b00)  begin bad++; $display("FAIL reset_txd got=%b want=00", txd); end
      total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy_o); end
      valid_i = 1'b0;
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL reset_release_busy got=%b want=0", busy_o); end
   endtask

   task automatic test_read();
      int n, g, lo;
      build_exp(16'h1234);
      send_req(16'h1234, 1'b0);
      total++; if (txen !== 1'b0) begin bad++; $display("FAIL read_accept_edge_txen got=%b want=0", txen); end
      @(posedge clk); #1;
      total++; if (txen !== 1'b1)   begin bad++; $display("FAIL read_first_edge_txen got=%b want=1", txen); end
      total++; if (busy_o !== 1'b1) begin bad++; $display("FAIL read_first_edge_busy got=%b want=1", busy_o); end
      capture(n);
      total++; if (n !== 288) begin bad++; $display("FAIL read_txen_len got=%0d want=288", n); end
      for (int i = 0; i < 72; i++) begin
         total++;
         if (fr[i] !== exp_fr[i]) begin bad++; $display("FAIL read_byte%0d got=%h want=%h", i, fr[i], exp_fr[i]); end
      end
      total++;
      if (crc_over(8, 71) !== 32'hDEBB_20E3) begin
         bad++; $display("FAIL read_residue got=%h want=debb20e3", crc_over(8, 71));
      end
      g = 0; lo = 0;
      while (busy_o && g < 100) begin
         if (txen) lo++;
         g++;
         @(posedge clk); #1;
      end
      total++; if (g !== 48)  begin bad++; $display("FAIL read_ifg_len got=%0d want=48", g); end
      total++; if (lo !== 0)  begin bad++; $display("FAIL read_ifg_txen got=%0d want=0", lo); end
   endtask

   task automatic test_write();
      int hi;
      send_req(16'hBEEF, 1'b1);
      hi = 0;
      repeat (400) begin
         @(posedge clk); #1;
         if (txen || busy_o) hi++;
      end
      total++; if (hi !== 0) begin bad++; $display("FAIL write_filter active_cycles got=%0d want=0", hi); end
   endtask

   task automatic test_back_to_back();
      logic th [0:700];
      logic bh [0:700];
      int rises, highs, ifg;
      send_req(16'h0F0F, 1'b0);
      th[0] = txen; bh[0] = busy_o;
      data_i = 16'h5678;
      for (int c = 1; c <= 700; c++) begin
         @(posedge clk); #1;
         th[c] = txen; bh[c] = busy_o;
         valid_i = ((c + 1) == 100) || ((c + 1) == 337);
      end
      valid_i = 1'b0;
      rises = 0; highs = 0; ifg = 0;
      for (int c = 1; c <= 700; c++) begin
         if (th[c] && !th[c-1]) rises++;
         if (th[c]) highs++;
         if (c >= 289 && c <= 337 && bh[c] && !th[c]) ifg++;
      end
      total++; if (rises !== 2)   begin bad++; $display("FAIL b2b_frames got=%0d want=2", rises); end
      total++; if (highs !== 576) begin bad++; $display("FAIL b2b_txen_cycles got=%0d want=576", highs); end
      total++; if (th[288] !== 1'b1 || th[289] !== 1'b0) begin
         bad++; $display("FAIL b2b_frame1_end got=%b%b want=10", th[288], th[289]);
      end
      total++; if (th[337] !== 1'b0 || th[338] !== 1'b1) begin
         bad++; $display("FAIL b2b_frame2_start got=%b%b want=01", th[337], th[338]);
      end
      total++; if (ifg !== 48) begin bad++; $display("FAIL b2b_ifg got=%0d want=48", ifg); end
      total++; if (th[625] !== 1'b1 || th[626] !== 1'b0) begin
         bad++; $display("FAIL b2b_frame2_end got=%b%b want=10", th[625], th[626]);
      end
   endtask

   task automatic test_reset_mid();
      int n, g;
      send_req(16'h1111, 1'b0);
      repeat (82) @(posedge clk);
      #1;
      total++; if (txen !== 1'b1) begin bad++; $display("FAIL rstmid_pre_txen got=%b want=1", txen); end
      rst = 1'b1;
      #2;
      total++; if (txen !== 1'b0)   begin bad++; $display("FAIL rstmid_async_txen got=%b want=0", txen); end
      total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL rstmid_async_busy got=%b want=0", busy_o); end
      total++; if (txd !== 2'b00)   begin bad++; $display("FAIL rstmid_async_txd got=%b want=00", txd); end
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      total++; if (txen !== 1'b0 || busy_o !== 1'b0) begin
         bad++; $display("FAIL rstmid_idle got=%b%b want=00", txen, busy_o);
      end
      build_exp(16'hA5A5);
      send_req(16'hA5A5, 1'b0);
      capture(n);
      total++; if (n !== 288) begin bad++; $display("FAIL rstmid_txen_len got=%0d want=288", n); end
      for (int i = 0; i < 72; i++) begin
         total++;
         if (fr[i] !== exp_fr[i]) begin bad++; $display("FAIL rstmid_byte%0d got=%h want=%h", i, fr[i], exp_fr[i]); end
      end
      g = 0;
      while (busy_o && g < 100) begin
         g++;
         @(posedge clk); #1;
      end
      total++; if (g !== 48) begin bad++; $display("FAIL rstmid_ifg_len got=%0d want=48", g); end
   endtask

   initial begin
      rst = 1'b1; data_i = '0; rw_i = 1'b0; valid_i = 1'b0;
      test_reset();
      test_read();
      test_write();
      test_back_to_back();
      repeat (60) @(posedge clk);
      #1;
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
